// File: rtl/forward_source_tracker_if.sv
// rtl/forward_source_tracker_if.sv - issue request and forwarding source bundle for forward_source_tracker
interface forward_source_tracker_if #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
);
    logic              issue_en;
    logic [REG_W-1:0]  issue_reg;
    logic [1:0]        issue_stage;
    logic [DATA_W-1:0] issue_value;

    logic              src1_valid;
    logic [REG_W-1:0]  src1_reg;
    logic [DATA_W-1:0] src1_value;
    logic              src2_valid;
    logic [REG_W-1:0]  src2_reg;
    logic [DATA_W-1:0] src2_value;
    logic              src3_valid;
    logic [REG_W-1:0]  src3_reg;
    logic [DATA_W-1:0] src3_value;
    logic [1:0]        pending_count;

    modport master (
        output issue_en, issue_reg, issue_stage, issue_value,
        input  src1_valid, src1_reg, src1_value,
        input  src2_valid, src2_reg, src2_value,
        input  src3_valid, src3_reg, src3_value,
        input  pending_count
    );

    modport slave (
        input  issue_en, issue_reg, issue_stage, issue_value,
        output src1_valid, src1_reg, src1_value,
        output src2_valid, src2_reg, src2_value,
        output src3_valid, src3_reg, src3_value,
        output pending_count
    );
endinterface

// File: rtl/forward_source_tracker.sv
// rtl/forward_source_tracker.sv - E/M/W in-flight write tracker feeding forwarding sources (optional FWD_STALL_STATS_EN)
module forward_source_tracker #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic                 clk,
    input  logic                 reset_n,
    forward_source_tracker_if.slave bus,
    input  logic                 stall_in,
    input  logic                 hold_in,
    input  logic                 flush_in,
    input  logic [DATA_W-1:0]    exec_result,
    input  logic [DATA_W-1:0]    mem_result
`ifdef FWD_STALL_STATS_EN
    ,
    output logic [31:0]          stall_cycles
`endif
);

    localparam logic [1:0] STG_DEC  = 2'd0;
    localparam logic [1:0] STG_EXEC = 2'd1;
    localparam logic [1:0] STG_MEM  = 2'd2;

    typedef struct packed {
        logic              occ;
        logic [REG_W-1:0]  dst;
        logic [1:0]        stage;
        logic              ready;
        logic [DATA_W-1:0] value;
    } slot_t;

    slot_t      e_q, m_q, w_q;
    slot_t      e_d, m_d, w_d;
    logic [1:0] pending_q, pending_d;

    always_comb begin
        e_d = e_q;
        m_d = m_q;
        w_d = w_q;
        if (hold_in) begin
            // Multi-cycle exec busy: everything freezes, but a branch kill still empties E.
            if (flush_in) begin
                e_d = '0;
            end
        end else begin
            w_d = m_q;
            if (m_q.occ && m_q.stage == STG_MEM) begin
                w_d.ready = 1'b1;
                w_d.value = mem_result;
            end
            m_d = e_q;
            if (e_q.occ && e_q.stage == STG_EXEC) begin
                m_d.ready = 1'b1;
                m_d.value = exec_result;
            end
            e_d = '0;
            if (bus.issue_en && !stall_in && !flush_in && bus.issue_reg != '0) begin
                e_d.occ   = 1'b1;
                e_d.dst   = bus.issue_reg;
                e_d.stage = bus.issue_stage;
                e_d.ready = (bus.issue_stage == STG_DEC);
                e_d.value = (bus.issue_stage == STG_DEC) ? bus.issue_value : '0;
            end
        end
        pending_d = {1'b0, e_d.occ & ~e_d.ready}
                  + {1'b0, m_d.occ & ~m_d.ready}
                  + {1'b0, w_d.occ & ~w_d.ready};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            e_q       <= '0;
            m_q       <= '0;
            w_q       <= '0;
            pending_q <= '0;
        end else begin
            e_q       <= e_d;
            m_q       <= m_d;
            w_q       <= w_d;
            pending_q <= pending_d;
        end
    end

    // Outputs come straight from slot state so consumers see no input-to-output path.
    assign bus.src1_valid    = e_q.occ & e_q.ready;
    assign bus.src1_reg      = e_q.occ ? e_q.dst : '0;
    assign bus.src1_value    = e_q.occ ? e_q.value : '0;
    assign bus.src2_valid    = m_q.occ & m_q.ready;
    assign bus.src2_reg      = m_q.occ ? m_q.dst : '0;
    assign bus.src2_value    = m_q.occ ? m_q.value : '0;
    assign bus.src3_valid    = w_q.occ & w_q.ready;
    assign bus.src3_reg      = w_q.occ ? w_q.dst : '0;
    assign bus.src3_value    = w_q.occ ? w_q.value : '0;
    assign bus.pending_count = pending_q;

`ifdef FWD_STALL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (stall_in || hold_in) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_forward_source_tracker.sv
// tb/tb_forward_source_tracker.sv - scoreboard bench for forward_source_tracker
module tb_forward_source_tracker;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_in, hold_in, flush_in;
    logic [31:0] exec_result, mem_result;
`ifdef FWD_STALL_STATS_EN
    logic [31:0] stall_cycles;
`endif

    forward_source_tracker_if #(.DATA_W(32), .REG_W(5)) bus ();

    forward_source_tracker #(.DATA_W(32), .REG_W(5)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .stall_in    (stall_in),
        .hold_in     (hold_in),
        .flush_in    (flush_in),
        .exec_result (exec_result),
        .mem_result  (mem_result)
`ifdef FWD_STALL_STATS_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          due;
        logic        v1;
        logic [4:0]  r1;
        logic [31:0] x1;
        logic        v2;
        logic [4:0]  r2;
        logic [31:0] x2;
        logic        v3;
        logic [4:0]  r3;
        logic [31:0] x3;
        logic [1:0]  pc;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    event chk_now;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input string f, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s actual=%h expected=%h", n, f, act, exp);
        end
    endtask

    // Monitor: compares every expectation whose edge has already happened.
    initial begin
        forever begin
            @(negedge clk or chk_now);
            while (q.size() > 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                chk(e.name, "src1_valid", {31'd0, bus.src1_valid}, {31'd0, e.v1});
                chk(e.name, "src1_reg",   {27'd0, bus.src1_reg},   {27'd0, e.r1});
                chk(e.name, "src1_value", bus.src1_value,          e.x1);
                chk(e.name, "src2_valid", {31'd0, bus.src2_valid}, {31'd0, e.v2});
                chk(e.name, "src2_reg",   {27'd0, bus.src2_reg},   {27'd0, e.r2});
                chk(e.name, "src2_value", bus.src2_value,          e.x2);
                chk(e.name, "src3_valid", {31'd0, bus.src3_valid}, {31'd0, e.v3});
                chk(e.name, "src3_reg",   {27'd0, bus.src3_reg},   {27'd0, e.r3});
                chk(e.name, "src3_value", bus.src3_value,          e.x3);
                chk(e.name, "pending",    {30'd0, bus.pending_count}, {30'd0, e.pc});
            end
        end
    end

    task automatic set_in(input logic en, input logic [4:0] r, input logic [1:0] st, input logic [31:0] v,
                          input logic stall, input logic hold, input logic flush,
                          input logic [31:0] ex, input logic [31:0] mem);
        bus.issue_en    = en;
        bus.issue_reg   = r;
        bus.issue_stage = st;
        bus.issue_value = v;
        stall_in        = stall;
        hold_in         = hold;
        flush_in        = flush;
        exec_result     = ex;
        mem_result      = mem;
    endtask

    task automatic expect_out(input string n, input bit imm,
                              input logic v1, input logic [4:0] r1, input logic [31:0] x1,
                              input logic v2, input logic [4:0] r2, input logic [31:0] x2,
                              input logic v3, input logic [4:0] r3, input logic [31:0] x3,
                              input logic [1:0] pc);
        exp_t t;
        t.name = n;
        t.due  = imm ? cyc : cyc + 1;
        t.v1 = v1; t.r1 = r1; t.x1 = x1;
        t.v2 = v2; t.r2 = r2; t.x2 = x2;
        t.v3 = v3; t.r3 = r3; t.x3 = x3;
        t.pc = pc;
        q.push_back(t);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        expect_out("reset", 1, 0,0,0, 0,0,0, 0,0,0, 0);
        ->chk_now;
        #1;
        reset_n = 1'b1;
        tick();

        // ALU chain
        set_in(1, 8, 1, 0, 0, 0, 0, 0, 0);
        expect_out("alu_e", 0, 0,8,0, 0,0,0, 0,0,0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 32'h1234, 0);
        expect_out("alu_m", 0, 0,0,0, 1,8,32'h1234, 0,0,0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("alu_w", 0, 0,0,0, 0,0,0, 1,8,32'h1234, 0); tick();
        expect_out("alu_out", 0, 0,0,0, 0,0,0, 0,0,0, 0); tick();

        // Load-use
        set_in(1, 9, 2, 0, 0, 0, 0, 32'hDEAD, 0);
        expect_out("ld_e", 0, 0,9,0, 0,0,0, 0,0,0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 32'hDEAD, 0);
        expect_out("ld_m", 0, 0,0,0, 0,9,0, 0,0,0, 1); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE);
        expect_out("ld_w", 0, 0,0,0, 0,0,0, 1,9,32'hCAFE, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("ld_out", 0, 0,0,0, 0,0,0, 0,0,0, 0); tick();

        // Decode-ready value must survive M and W untouched
        set_in(1, 31, 0, 32'h0040_0008, 0, 0, 0, 32'h5555, 32'h7777);
        expect_out("jal_e", 0, 1,31,32'h0040_0008, 0,0,0, 0,0,0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 32'h5555, 32'h7777);
        expect_out("jal_m", 0, 0,0,0, 1,31,32'h0040_0008, 0,0,0, 0); tick();
        expect_out("jal_w", 0, 0,0,0, 0,0,0, 1,31,32'h0040_0008, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("jal_out", 0, 0,0,0, 0,0,0, 0,0,0, 0); tick();

        // Stall, then fill all slots, then hold and flush-under-hold
        set_in(1, 5, 1, 0, 0, 0, 0, 0, 0);
        expect_out("st_e", 0, 0,5,0, 0,0,0, 0,0,0, 1); tick();
        set_in(1, 6, 0, 32'h66, 1, 0, 0, 32'hAA, 0);
        expect_out("stall", 0, 0,0,0, 1,5,32'hAA, 0,0,0, 0); tick();
        set_in(1, 7, 3, 0, 0, 0, 0, 0, 0);
        expect_out("wb_e", 0, 0,7,0, 0,0,0, 1,5,32'hAA, 1); tick();
        set_in(1, 10, 2, 0, 0, 0, 0, 32'h99, 0);
        expect_out("fill2", 0, 0,10,0, 0,7,0, 0,0,0, 2); tick();
        set_in(1, 11, 1, 0, 0, 0, 0, 0, 32'h44);
        expect_out("fill3", 0, 0,11,0, 0,10,0, 0,7,0, 3); tick();
        for (int i = 0; i < 3; i++) begin
            set_in(1, 12, 0, 32'h12, 0, 1, 0, 32'h11, 32'h22);
            expect_out("hold", 0, 0,11,0, 0,10,0, 0,7,0, 3); tick();
        end
        set_in(1, 12, 0, 32'h12, 0, 1, 1, 32'h11, 32'h22);
        expect_out("hold_flush", 0, 0,0,0, 0,10,0, 0,7,0, 2); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 32'h33);
        expect_out("release", 0, 0,0,0, 0,0,0, 1,10,32'h33, 0); tick();

        // Flush without hold: E still advances, new issue dropped
        set_in(1, 12, 1, 0, 0, 0, 0, 0, 0);
        expect_out("fl_e", 0, 0,12,0, 0,0,0, 0,0,0, 1); tick();
        set_in(1, 13, 0, 32'h13, 0, 0, 1, 32'h1212, 0);
        expect_out("flush", 0, 0,0,0, 1,12,32'h1212, 0,0,0, 0); tick();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        expect_out("fl_w", 0, 0,0,0, 0,0,0, 1,12,32'h1212, 0); tick();

        // Register 0 is never tracked
        set_in(1, 14, 3, 0, 0, 0, 0, 0, 0);
        expect_out("r14_e", 0, 0,14,0, 0,0,0, 0,0,0, 1); tick();
        set_in(1, 0, 0, 32'hFFFF, 0, 0, 0, 0, 0);
        expect_out("reg0", 0, 0,0,0, 0,14,0, 0,0,0, 1); tick();

        // Fill three slots then reset asynchronously between edges
        set_in(1, 1, 0, 32'h1, 0, 0, 0, 0, 0);
        expect_out("r_1", 0, 1,1,32'h1, 0,0,0, 0,14,0, 1); tick();
        set_in(1, 2, 0, 32'h2, 0, 0, 0, 0, 0);
        expect_out("r_2", 0, 1,2,32'h2, 1,1,32'h1, 0,0,0, 0); tick();
        set_in(1, 3, 2, 0, 0, 0, 0, 0, 0);
        expect_out("r_3", 0, 0,3,0, 1,2,32'h2, 1,1,32'h1, 1); tick();
        @(negedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        expect_out("async_reset", 1, 0,0,0, 0,0,0, 0,0,0, 0);
        ->chk_now;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset_n = 1'b1;
        expect_out("post_reset", 0, 0,0,0, 0,0,0, 0,0,0, 0); tick();

        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
